uart_fifo_core: RTL

//  Full-duplex UART with internal baud generator, TX/RX FIFOs and per-word RX error flags; next-gen UART top.

---
 rtl/uart_fifo_core.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_core.sv
// Full-duplex UART: shared baud tick, TX/RX first-word-fall-through FIFOs,
// oversampled receiver with per-word parity and framing flags.
`timescale 1ns/1ps

module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd && !empty;
  // a full buffer still takes a word when one leaves in the same cycle
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end
endmodule

module uart_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          par_en,
  input  logic                          par_type,
  input  logic                          stop2,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_par_error,
  output logic                          rx_frame_error,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic                          overrun,
  output logic                          tx_busy,
  output logic                          tx_ser,
  input  logic                          rx_ser
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 2);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_WIDTH - 1);

  // IDLE wait | START | DATA lsb first | PARITY optional | STOP 1 or 2 bits
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DIV_WIDTH-1:0] tick_cnt;
  logic                 tick;

  assign tick = (tick_cnt >= baud_div);

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 1'b1;
  end

  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_full, tx_empty, tx_pop;

  uart_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr_data(tx_data), .wr(tx_valid && tx_ready),
    .rd(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty),
    .count(tx_fifo_count)
  );

  assign tx_ready = !tx_full;

  state_t                tx_state, tx_state_n;
  logic [OSW-1:0]        tx_os, tx_os_n;
  logic [BW-1:0]         tx_bit, tx_bit_n;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_n;
  logic                  tx_par, tx_par_n, tx_par_en, tx_par_en_n;
  logic                  tx_stop_left, tx_stop_left_n, tx_ser_n;
  logic                  tx_bit_end, tx_load;

  assign tx_bit_end = tick && (tx_os == '0);
  assign tx_busy    = (tx_state != S_IDLE) || !tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= S_IDLE;
      tx_os        <= '0;
      tx_bit       <= '0;
      tx_sh        <= '0;
      tx_par       <= 1'b0;
      tx_par_en    <= 1'b0;
      tx_stop_left <= 1'b0;
      tx_ser       <= 1'b1;
    end else begin
      tx_state     <= tx_state_n;
      tx_os        <= tx_os_n;
      tx_bit       <= tx_bit_n;
      tx_sh        <= tx_sh_n;
      tx_par       <= tx_par_n;
      tx_par_en    <= tx_par_en_n;
      tx_stop_left <= tx_stop_left_n;
      tx_ser       <= tx_ser_n;
    end
  end

  always_comb begin
    tx_state_n     = tx_state;
    tx_bit_n       = tx_bit;
    tx_sh_n        = tx_sh;
    tx_par_n       = tx_par;
    tx_par_en_n    = tx_par_en;
    tx_stop_left_n = tx_stop_left;
    tx_ser_n       = tx_ser;
    tx_load        = 1'b0;
    tx_pop         = 1'b0;
    tx_os_n        = tx_os;
    if (tick && tx_state != S_IDLE) tx_os_n = (tx_os == '0) ? OS_LAST : tx_os - 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_ser_n = 1'b1;
        if (tick && !tx_empty) tx_load = 1'b1;
      end
      S_START: if (tx_bit_end) begin
        tx_state_n = S_DATA;
        tx_ser_n   = tx_sh[0];
        tx_bit_n   = BIT_LAST;
      end
      S_DATA: if (tx_bit_end) begin
        if (tx_bit != '0) begin
          tx_sh_n  = tx_sh >> 1;
          tx_ser_n = tx_sh[1];
          tx_bit_n = tx_bit - 1'b1;
        end else if (tx_par_en) begin
          tx_state_n = S_PARITY;
          tx_ser_n   = tx_par;
        end else begin
          tx_state_n = S_STOP;
          tx_ser_n   = 1'b1;
        end
      end
      S_PARITY: if (tx_bit_end) begin
        tx_state_n = S_STOP;
        tx_ser_n   = 1'b1;
      end
      S_STOP: if (tx_bit_end) begin
        if (tx_stop_left)   tx_stop_left_n = 1'b0;
        else if (!tx_empty) tx_load = 1'b1;
        else                tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
    // a queued word starts straight out of STOP, so frames run back to back
    if (tx_load) begin
      tx_pop         = 1'b1;
      tx_state_n     = S_START;
      tx_ser_n       = 1'b0;
      tx_os_n        = OS_LAST;
      tx_sh_n        = tx_head;
      tx_par_n       = ^tx_head ^ par_type;
      tx_par_en_n    = par_en;
      tx_stop_left_n = stop2;
    end
  end

  logic rx_meta, rx_s, rx_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_ser;
      rx_s    <= rx_meta;
      if (tick) rx_prev <= rx_s;
    end
  end

  state_t                rx_state, rx_state_n;
  logic [OSW-1:0]        rx_os, rx_os_n;
  logic [BW-1:0]         rx_bit, rx_bit_n;
  logic [DATA_WIDTH-1:0] rx_sh, rx_sh_n;
  logic                  rx_par, rx_par_n, rx_par_en, rx_par_en_n, rx_par_type, rx_par_type_n;
  logic                  rx_sample, rx_push, rx_full, rx_empty;
  logic [DATA_WIDTH+1:0] rx_word, rx_head;

  assign rx_sample = tick && (rx_os == '0);
  assign rx_word   = {~rx_s, rx_par_en && (rx_par != (^rx_sh ^ rx_par_type)), rx_sh};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= S_IDLE;
      rx_os       <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_par      <= 1'b0;
      rx_par_en   <= 1'b0;
      rx_par_type <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_state    <= rx_state_n;
      rx_os       <= rx_os_n;
      rx_bit      <= rx_bit_n;
      rx_sh       <= rx_sh_n;
      rx_par      <= rx_par_n;
      rx_par_en   <= rx_par_en_n;
      rx_par_type <= rx_par_type_n;
      overrun     <= rx_push && rx_full && !rx_ready;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_bit_n      = rx_bit;
    rx_sh_n       = rx_sh;
    rx_par_n      = rx_par;
    rx_par_en_n   = rx_par_en;
    rx_par_type_n = rx_par_type;
    rx_push       = 1'b0;
    rx_os_n       = rx_os;
    if (tick && rx_state != S_IDLE) rx_os_n = (rx_os == '0) ? OS_LAST : rx_os - 1'b1;
    case (rx_state)
      S_IDLE: if (tick && !rx_s && rx_prev) begin
        rx_state_n    = S_START;
        rx_os_n       = OS_HALF;
        rx_par_en_n   = par_en;
        rx_par_type_n = par_type;
      end
      S_START: if (rx_sample) begin
        rx_state_n = rx_s ? S_IDLE : S_DATA;
        rx_bit_n   = BIT_LAST;
      end
      S_DATA: if (rx_sample) begin
        rx_sh_n = {rx_s, rx_sh[DATA_WIDTH-1:1]};
        if (rx_bit != '0)   rx_bit_n = rx_bit - 1'b1;
        else if (rx_par_en) rx_state_n = S_PARITY;
        else                rx_state_n = S_STOP;
      end
      S_PARITY: if (rx_sample) begin
        rx_par_n   = rx_s;
        rx_state_n = S_STOP;
      end
      // back to IDLE mid-stop so the next start edge is caught early
      S_STOP: if (rx_sample) begin
        rx_push    = 1'b1;
        rx_state_n = S_IDLE;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  uart_fifo_buf #(.WIDTH(DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr_data(rx_word), .wr(rx_push),
    .rd(rx_ready), .rd_data(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_fifo_count)
  );

  assign rx_valid       = !rx_empty;
  assign rx_data        = rx_head[DATA_WIDTH-1:0];
  assign rx_par_error   = rx_head[DATA_WIDTH];
  assign rx_frame_error = rx_head[DATA_WIDTH+1];
endmodule
